// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze controller for a 5-stage MIPS pipeline, with a small FSM that freezes
// the whole pipeline during multi-cycle data-memory accesses. Optional macro: FORWARDING_EN.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W      = 5,
    parameter int MEM_WAIT_CYCLES = 4,
    parameter int CNT_W           = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  two_src,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_wb_en,
    input  logic                  exe_mem_r_en,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic                  mem_access,
    input  logic                  branch_taken,
    output logic                  freeze_pc,
    output logic                  freeze_if_id,
    output logic                  bubble_id_exe,
    output logic                  flush_if_id,
    output logic                  freeze_all,
    output logic                  mem_start,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_WAIT_CYCLES - 3);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard;

`ifdef FORWARDING_EN
    // ALU results are forwarded; only a load in EXE feeding the ID instruction must stall.
    assign hazard = exe_mem_r_en && exe_wb_en && (exe_dest != '0) &&
                    ((src1 == exe_dest) || (two_src && (src2 == exe_dest)));

    logic unused_mem_inputs;
    assign unused_mem_inputs = ^{mem_dest, mem_wb_en};
`else
    logic src1_hit, src2_hit;

    assign src1_hit = (src1 != '0) &&
                      ((exe_wb_en && (src1 == exe_dest)) || (mem_wb_en && (src1 == mem_dest)));
    assign src2_hit = (src2 != '0) &&
                      ((exe_wb_en && (src2 == exe_dest)) || (mem_wb_en && (src2 == mem_dest)));
    assign hazard   = src1_hit || (two_src && src2_hit);

    logic unused_load_flag;
    assign unused_load_flag = exe_mem_r_en;
`endif

    logic freeze_pc_c, freeze_if_id_c, bubble_id_exe_c, flush_if_id_c, freeze_all_c, mem_start_c;

    // NOTE: every signal assigned here gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        freeze_pc_c     = 1'b0;
        freeze_if_id_c  = 1'b0;
        bubble_id_exe_c = 1'b0;
        flush_if_id_c   = 1'b0;
        freeze_all_c    = 1'b0;
        mem_start_c     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_access) begin
                    freeze_all_c = 1'b1;
                    mem_start_c  = 1'b1;
                    cnt_d        = CNT_LOAD;
                    state_d      = MEM_WAIT;
                end else if (branch_taken) begin
                    flush_if_id_c   = 1'b1;
                    bubble_id_exe_c = 1'b1;
                end else if (hazard) begin
                    freeze_pc_c     = 1'b1;
                    freeze_if_id_c  = 1'b1;
                    bubble_id_exe_c = 1'b1;
                end
            end
            MEM_WAIT: begin
                freeze_all_c = 1'b1;
                if (cnt_q == '0) begin
                    state_d = MEM_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            MEM_DONE: begin
                // The completing access still drives mem_access here; it must not relaunch.
                state_d = IDLE;
                if (branch_taken) begin
                    flush_if_id_c   = 1'b1;
                    bubble_id_exe_c = 1'b1;
                end else if (hazard) begin
                    freeze_pc_c     = 1'b1;
                    freeze_if_id_c  = 1'b1;
                    bubble_id_exe_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are forced low while reset is held, whatever the inputs do.
    assign freeze_pc     = rst & freeze_pc_c;
    assign freeze_if_id  = rst & freeze_if_id_c;
    assign bubble_id_exe = rst & bubble_id_exe_c;
    assign flush_if_id   = rst & flush_if_id_c;
    assign freeze_all    = rst & freeze_all_c;
    assign mem_start     = rst & mem_start_c;
    assign state         = state_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush/freeze controller for the 5-stage MIPS pipeline (IF, ID, EXE, MEM, WB).
- Inputs: ID-stage source registers, EXE/MEM destination and control bits, the EXE branch decision, and the MEM access request.
- Outputs: per-stage hold/bubble/flush controls.
- Sequences multi-cycle data-memory accesses with a small FSM, freezing the whole pipeline until the access completes.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- MEM_WAIT_CYCLES, 4, total cycles a data-memory access occupies MEM; legal range 3..15.
- CNT_W, 4, wait-counter width; must satisfy 2^CNT_W > MEM_WAIT_CYCLES.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- src1  in  REG_ADDR_W  rs of the instruction in ID.
- src2  in  REG_ADDR_W  rt of the instruction in ID.
- two_src  in  1  instruction in ID reads src2 (R-type, store, branch).
- exe_dest  in  REG_ADDR_W  destination of the instruction in EXE.
- exe_wb_en  in  1  instruction in EXE writes back.
- exe_mem_r_en  in  1  instruction in EXE is a load.
- mem_dest  in  REG_ADDR_W  destination of the instruction in MEM.
- mem_wb_en  in  1  instruction in MEM writes back.
- mem_access  in  1  instruction in MEM reads or writes data memory.
- branch_taken  in  1  EXE resolved a taken branch this cycle.
- freeze_pc  out  1  hold the PC.
- freeze_if_id  out  1  hold the IF/ID register.
- bubble_id_exe  out  1  load a NOP (all enables 0) into ID/EXE.
- flush_if_id  out  1  clear IF/ID to a NOP.
- freeze_all  out  1  hold every pipeline register and the PC; overrides all other controls.
- mem_start  out  1  one-cycle pulse launching a data-memory access.
- state  out  2  FSM state for debug: 0 IDLE, 1 MEM_WAIT, 2 MEM_DONE.

Behaviour:
- Reset:
  - While rst=0: state=IDLE, wait counter=0, all outputs 0 regardless of inputs.
  - Reset asserted mid-access aborts it immediately; after release the controller is in IDLE.
- Hazard term H:
  - H = (src1!=0 && ((exe_wb_en && src1==exe_dest) || (mem_wb_en && src1==mem_dest))) || (two_src && src2!=0 && same match on src2).
  - Register 0 never causes a hazard.
- IDLE, priority order:
  1. mem_access=1: freeze_all=1 and mem_start=1 this cycle; all other outputs 0; load counter=MEM_WAIT_CYCLES-3; next state MEM_WAIT.
  2. branch_taken=1: flush_if_id=1, bubble_id_exe=1, freezes 0; H ignored.
  3. H=1: freeze_pc=1, freeze_if_id=1, bubble_id_exe=1.
  4. Otherwise all outputs 0.
- MEM_WAIT:
  - freeze_all=1; all other outputs 0; branch_taken and H ignored because the pipeline is held.
  - If counter==0, next state MEM_DONE; else decrement.
- MEM_DONE:
  - Exactly one cycle; freeze_all=0; the pipeline advances.
  - mem_access is ignored (it still reflects the completing instruction).
  - branch/H logic as IDLE items 2-4; next state IDLE.
- Timing:
  - freeze_all is high for exactly MEM_WAIT_CYCLES-1 consecutive cycles per access.
  - The access instruction leaves MEM at the end of the MEM_DONE cycle.
  - mem_start pulses once per access.
- Combinational paths:
  - All outputs are combinational from the registered state plus current inputs; no input-to-state path except through the counter/state registers.
  - Zero-latency response to H and branch_taken.
- Back-to-back accesses: mem_access=1 on the cycle after MEM_DONE starts a new access from IDLE.

Optional Feature:
- Macro FORWARDING_EN.
- Defined:
  - The forwarding unit resolves ALU hazards, so only load-use hazards stall.
  - H = exe_mem_r_en && exe_wb_en && exe_dest!=0 && (src1==exe_dest || (two_src && src2==exe_dest)).
  - mem_dest and mem_wb_en are unused.
- Undefined: full H as above; EXE and MEM matches both stall.

Test Plan:
- Reset: rst=0 with mem_access=1, branch_taken=1 -> all outputs 0, state=0; release rst -> next edge with mem_access=1 gives mem_start=1, freeze_all=1.
- Memory wait, MEM_WAIT_CYCLES=4: mem_access=1 held -> freeze_all=1 for 3 cycles, state 0,1,1,2; 4th cycle freeze_all=0; mem_start high only in cycle 1.
- RAW hazard, FORWARDING_EN undefined: src1=3, exe_dest=3, exe_wb_en=1 -> freeze_pc=freeze_if_id=bubble_id_exe=1. src1=0, exe_dest=0 -> all 0. src2=5, two_src=0, mem_dest=5 -> all 0.
- Load-use, FORWARDING_EN defined:
  - src1=7, exe_dest=7, exe_wb_en=1, exe_mem_r_en=0 -> no stall.
  - Same with exe_mem_r_en=1 -> stall.
  - mem_dest=7, mem_wb_en=1 alone -> no stall.
- Priorities:
  - branch_taken=1 with H=1 in IDLE -> flush_if_id=1, bubble_id_exe=1, freeze_pc=0.
  - branch_taken=1 during MEM_WAIT -> only freeze_all=1; held branch_taken in MEM_DONE -> flush_if_id=1.
- Reset mid-access: rst=0 during MEM_WAIT -> state=0, freeze_all=0 immediately (asynchronous); after release with mem_access=0 -> outputs 0.
